fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side controller for the team's `fifo` block. It watches the FIFO status flags, issues `rd_en` pops, and registers the combinational `rd_data` into a one-deep valid/ready output stage. Data leaves as fixed-length bursts when the FIFO is almost full, or as single-beat transfers when draining. It sits between a `fifo` instance and a downstream consumer such as a DMA or packetiser.

## Interface
- `width`, 32: data word width; must match the attached `fifo`.
- `burst_len`, 8: beats per burst; must be ≤ the FIFO's almost-full threshold + 1.
- `timeout_cycles`, 256: idle-with-data cycles before auto-drain; used only with the macro below.
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `fifo_rd_en`  out  1: pop strobe to the FIFO.
- `fifo_rd_data`  in  width: FIFO read bus, combinational from the FIFO read pointer.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_almost_full`  in  1: FIFO almost-full flag.
- `flush_req`  in  1: level; drain the FIFO to empty as single beats.
- `out_valid`  out  1: output word valid.
- `out_ready`  in  1: consumer accepts the word.
- `out_data`  out  width: output word.
- `out_last`  out  1: marks the final beat of a burst; always 1 for drain beats.
- `busy`  out  1: state ≠ IDLE or `out_valid`=1.

## Operation
- States:
  - IDLE: waits for a trigger.
  - BURST: transfers `burst_len` beats.
  - DRAIN: transfers one beat.
- Transitions:
  - IDLE→BURST when `fifo_almost_full`=1 (highest priority). The beat counter loads `burst_len`.
  - IDLE→DRAIN when `flush_req`=1 or the timeout has fired, and `fifo_empty`=0.
  - BURST→IDLE on the pop that takes the counter from 1 to 0.
  - DRAIN→IDLE after its single pop.
- Pop condition: state ∈ {BURST, DRAIN} and `fifo_empty`=0 and (`out_valid`=0 or `out_ready`=1) and, in BURST, beats left > 0.
- `fifo_rd_en` equals the pop condition exactly. It is never asserted while `fifo_empty`=1, because the FIFO counter would decrement past zero.
- Stalls:
  - If `fifo_empty` goes high mid-BURST, the block stays in BURST without popping until data returns.
  - The beat counter never goes below 0.
- On a pop, `fifo_rd_data` is captured into `out_data`, `out_valid` is set, and `out_last` is set to (DRAIN, or BURST with beats left = 1).
- Output handshake:
  - A word transfers on `out_valid` & `out_ready`.
  - `out_data` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` falls after a transfer unless a new pop occurs in the same cycle.
- Beat counter width is $clog2(burst_len+1).
- `flush_req` dropping while in DRAIN does not abort that beat.

## Timing
- Reset values: `fifo_rd_en`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, state IDLE, counter 0.
- Reset is asynchronous and takes effect mid-burst. Words already popped but not yet accepted are lost; the system resets the FIFO in the same reset domain.
- Latency:
  - Trigger seen in IDLE at edge N: state changes at N, first `fifo_rd_en` in cycle N+1, `out_valid` from N+2.
  - Burst throughput is 1 beat/cycle when `out_ready`=1 and the FIFO is not empty.
  - Drain throughput is 1 beat per 2 cycles, because each beat passes back through IDLE.
- `fifo_almost_full` rising during a drain sequence takes effect at the next IDLE cycle.
- A pop and an output transfer in the same cycle: the new word replaces the old one with no bubble.

## Configuration
- `FIFO_BURST_READER_TIMEOUT_EN` defined:
  - A counter increments each cycle in IDLE with `fifo_empty`=0 and `fifo_almost_full`=0.
  - It clears on any pop, on `fifo_empty`=1, or on reset.
  - At `timeout_cycles` it asserts an internal drain request, held until `fifo_empty`=1.
- Undefined: no counter logic is present; drain starts only on `flush_req`.

## Structure
- Package `fifo_burst_reader_pkg`: state enum (IDLE, BURST, DRAIN) and a function for the beat/timeout counter width.
- Sub-module `fifo_burst_reader_timer`: the timeout counter, instantiated only under the macro.

## Test plan
(`width`=32, `burst_len`=8, `timeout_cycles`=16)
- Fill the FIFO with 0x1..0x19 (25 words, almost full); `out_ready`=1 → exactly 8 pops; `out_data` 0x1..0x8 on consecutive cycles; `out_last`=1 only with 0x8; back to IDLE.
- Same as above, with `out_ready` low for 3 cycles at beat 4 → `fifo_rd_en` low for those cycles; 0x4 held stable; no word lost or duplicated.
- 3 words 0xA, 0xB, 0xC with `flush_req`=1 → three single beats, each with `out_last`=1; `fifo_rd_en` never asserted with `fifo_empty`=1; `busy`=0 afterwards.
- `reset_n` pulsed low during beat 5 of a burst → all outputs 0 immediately; IDLE after release.
- With the macro: 2 words and no flush → drain begins 16 idle cycles later. Without the macro → no pops occur.
- FIFO empties mid-burst at beat 6, refills after 5 cycles → burst resumes; `out_last` on the 8th beat.

Source files
------------

// File: rtl/fifo_burst_reader_pkg.sv
// Shared state encoding and counter sizing for the FIFO burst reader.
package fifo_burst_reader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StBurst = 2'd1;
    localparam state_t StDrain = 2'd2;

    // Bits needed to hold the values 0..n inclusive (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_timer.sv
// Idle-with-data timeout: requests an auto-drain after timeout_cycles quiet IDLE cycles.
// Instantiated only when FIFO_BURST_READER_TIMEOUT_EN is defined.
module fifo_burst_reader_timer
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned timeout_cycles = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic idle_i,
    input  logic fifo_empty_i,
    input  logic fifo_almost_full_i,
    input  logic pop_i,
    output logic drain_req_o
);

    localparam int unsigned TmoW = cnt_width(timeout_cycles);

    logic [TmoW-1:0] cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            hit;

    assign hit = (cnt_q == TmoW'(timeout_cycles));

    always_comb begin
        cnt_d = cnt_q;
        if (pop_i || fifo_empty_i) begin
            cnt_d = '0;
        end else if (idle_i && !fifo_almost_full_i && !hit) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Once fired, keep requesting drains until the FIFO has been emptied.
        req_d = !fifo_empty_i && (req_q || hit);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            req_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
        end
    end

    assign drain_req_o = req_q || hit;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side controller for a fifo: pops fixed-length bursts on almost-full, single beats on
// drain, into a one-deep valid/ready output stage. Optional macro: FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned width          = 32,
    parameter int unsigned burst_len      = 8,
    parameter int unsigned timeout_cycles = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             fifo_rd_en,
    input  logic [width-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    input  logic             fifo_almost_full,
    input  logic             flush_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned CntW = cnt_width(burst_len);

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [width-1:0] out_data_q, out_data_d;
    logic             pop;
    logic             tmo_req;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    fifo_burst_reader_timer #(
        .timeout_cycles(timeout_cycles)
    ) u_timer (
        .clk_i             (clk),
        .rst_ni            (reset_n),
        .idle_i            (state_q == StIdle),
        .fifo_empty_i      (fifo_empty),
        .fifo_almost_full_i(fifo_almost_full),
        .pop_i             (pop),
        .drain_req_o       (tmo_req)
    );
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^timeout_cycles;
    assign tmo_req = 1'b0;
`endif

    // Never pop an empty FIFO, and only pop when the output stage frees up this cycle.
    assign pop = ((state_q == StBurst && cnt_q != '0) || state_q == StDrain) &&
                 !fifo_empty && (!out_valid_q || out_ready);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (fifo_almost_full) begin
                    state_d = StBurst;
                    cnt_d   = CntW'(burst_len);
                end else if ((flush_req || tmo_req) && !fifo_empty) begin
                    state_d = StDrain;
                end
            end
            StBurst: begin
                if (pop) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            StDrain: begin
                if (pop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_rd_data;
            out_last_d  = (state_q == StDrain) || (cnt_q == CntW'(1));
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign fifo_rd_en = pop;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != StIdle) || out_valid_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO plus an expected-beat scoreboard.
// Define FIFO_BURST_READER_TIMEOUT_EN for both bench and RTL to cover the timeout build.
module tb_fifo_burst_reader;

    localparam int W        = 32;
    localparam int BL       = 8;
    localparam int TMO      = 16;
    localparam int AF_LEVEL = 24;
    localparam int DEPTH    = 64;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_rd_data;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic          flush_req = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .width         (W),
        .burst_len     (BL),
        .timeout_cycles(TMO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_empty      (fifo_empty),
        .fifo_almost_full(fifo_almost_full),
        .flush_req       (flush_req),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy)
    );

    // Behavioural FIFO, reset in the same domain as the reader.
    logic [31:0] mem [DEPTH];
    int          wr_ptr, rd_ptr, count, pops, cyc, first_pop, last_pop;
    logic        push_en = 1'b0;
    logic [31:0] push_data = '0;
    logic        af_force = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= 0;
            rd_ptr    <= 0;
            count     <= 0;
            pops      <= 0;
            cyc       <= 0;
            first_pop <= 0;
            last_pop  <= 0;
        end else begin
            cyc <= cyc + 1;
            if (push_en) begin
                mem[wr_ptr % DEPTH] <= push_data;
                wr_ptr <= wr_ptr + 1;
            end
            if (fifo_rd_en && count > 0) begin
                rd_ptr   <= rd_ptr + 1;
                pops     <= pops + 1;
                last_pop <= cyc + 1;
                if (pops == 0) first_pop <= cyc + 1;
            end
            count <= count + (push_en ? 1 : 0) - ((fifo_rd_en && count > 0) ? 1 : 0);
        end
    end

    assign fifo_rd_data     = (count > 0) ? mem[rd_ptr % DEPTH] : 32'h0;
    assign fifo_empty       = (count == 0);
    assign fifo_almost_full = (count >= AF_LEVEL) || af_force;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;
    logic        held_l = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inspect the cycle about to be clocked, then advance to the next falling edge.
    task automatic tick();
        beat_t b;
        #1;
        if (fifo_empty) chk("rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
        if (held_v) begin
            chk("hold_data", out_data, held_d);
            chk("hold_last", {31'd0, out_last}, {31'd0, held_l});
        end
        if (out_valid && !out_ready) chk("pop_while_stalled", {31'd0, fifo_rd_en}, 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_word", {31'd0, out_valid}, 32'd0);
            end else begin
                b = exp_q.pop_front();
                chk("out_data", out_data, b.data);
                chk("out_last", {31'd0, out_last}, {31'd0, b.last});
            end
        end
        held_v = out_valid && !out_ready && reset_n;
        held_d = out_data;
        held_l = out_last;
        @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] d);
        push_en   = 1'b1;
        push_data = d;
        tick();
        push_en   = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        exp_q.delete();
        held_v    = 1'b0;
        push_en   = 1'b0;
        af_force  = 1'b0;
        flush_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        tick();
        while (busy && k < limit) begin
            tick();
            k++;
        end
        chk("reached_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        int          d;

        // Reset values
        #1 reset_n = 1'b0;
        #1;
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        do_reset();

        // Full-speed burst of 8 out of 25 words
        out_ready = 1'b1;
        for (int i = 1; i <= BL; i++) expect_beat(32'(i), i == BL);
        for (int i = 1; i <= 25; i++) push_word(32'(i));
        wait_idle(40);
        chk("burst_pops", 32'(pops), 32'd8);
        chk("burst_span", 32'(last_pop - first_pop), 32'd7);
        chk("burst_exp_left", 32'(exp_q.size()), 32'd0);
        chk("burst_fifo_left", 32'(count), 32'd17);

        // Burst with a 3-cycle consumer stall on beat 4
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= BL; i++) expect_beat(32'(i), i == BL);
        for (int i = 1; i <= 25; i++) push_word(32'(i));
        for (int k = 0; k < 20 && !(out_valid && out_data == 32'd4); k++) tick();
        chk("stall_saw_beat4", out_data, 32'd4);
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        wait_idle(40);
        chk("stall_pops", 32'(pops), 32'd8);
        chk("stall_exp_left", 32'(exp_q.size()), 32'd0);
        chk("stall_fifo_left", 32'(count), 32'd17);

        // Flush-driven drain of three words
        do_reset();
        out_ready = 1'b1;
        push_word(32'hA);
        push_word(32'hB);
        push_word(32'hC);
        expect_beat(32'hA, 1'b1);
        expect_beat(32'hB, 1'b1);
        expect_beat(32'hC, 1'b1);
        flush_req = 1'b1;
        for (int k = 0; k < 20 && !fifo_empty; k++) tick();
        flush_req = 1'b0;
        wait_idle(20);
        chk("drain_pops", 32'(pops), 32'd3);
        chk("drain_span", 32'(last_pop - first_pop), 32'd4);
        chk("drain_exp_left", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during beat 5 of a burst
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= BL; i++) expect_beat(32'(i), i == BL);
        for (int i = 1; i <= 25; i++) push_word(32'(i));
        for (int k = 0; k < 20 && !(out_valid && out_data == 32'd5); k++) tick();
        chk("rst_mid_saw_beat5", out_data, 32'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_data", out_data, 32'd0);
        chk("rst_mid_last", {31'd0, out_last}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        held_v = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("rst_after_busy", {31'd0, busy}, 32'd0);
        chk("rst_after_pops", 32'(pops), 32'd0);

        // Two words, no flush: timeout drain or nothing
        do_reset();
        out_ready = 1'b1;
        push_word(32'h11);
        d = cyc;
        push_word(32'h22);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        expect_beat(32'h11, 1'b1);
        expect_beat(32'h22, 1'b1);
        for (int k = 0; k < 40 && pops == 0; k++) tick();
        chk("tmo_window", {31'd0, (first_pop - d >= TMO) && (first_pop - d <= TMO + 4)}, 32'd1);
        wait_idle(20);
        chk("tmo_pops", 32'(pops), 32'd2);
        chk("tmo_exp_left", 32'(exp_q.size()), 32'd0);
`else
        repeat (40) tick();
        chk("no_tmo_pops", 32'(pops), 32'd0);
        chk("no_tmo_busy", {31'd0, busy}, 32'd0);
        chk("no_tmo_count", 32'(count), 32'd2);
`endif

        // FIFO runs dry after beat 5, refilled 5 cycles later
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push_word(32'h60 + 32'(i));
        for (int i = 1; i <= BL; i++) expect_beat(32'h60 + 32'(i), i == BL);
        af_force = 1'b1;
        tick();
        af_force = 1'b0;
        for (int k = 0; k < 20 && pops < 5; k++) tick();
        chk("dry_pops5", 32'(pops), 32'd5);
        repeat (5) begin
            tick();
            chk("dry_busy", {31'd0, busy}, 32'd1);
        end
        for (int i = 6; i <= BL; i++) push_word(32'h60 + 32'(i));
        wait_idle(20);
        chk("dry_pops", 32'(pops), 32'd8);
        chk("dry_exp_left", 32'(exp_q.size()), 32'd0);

        // Random data with random back-pressure
        repeat (3) begin
            do_reset();
            for (int i = 1; i <= 25; i++) begin
                w = $urandom;
                if (i <= BL) expect_beat(w, i == BL);
                out_ready = 1'($urandom_range(0, 1));
                push_word(w);
            end
            repeat (60) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            out_ready = 1'b1;
            wait_idle(40);
            chk("rand_pops", 32'(pops), 32'd8);
            chk("rand_exp_left", 32'(exp_q.size()), 32'd0);
            chk("rand_fifo_left", 32'(count), 32'd17);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
